// File: rtl/ika2151_bus_master.sv
// ika2151_bus_master: host-side OPM CPU bus initiator.
// Polls busy status, then writes register address and data.
module ika2151_bus_master #(
    parameter int SETUP_CYC    = 2,
    parameter int PULSE_CYC    = 4,
    parameter int HOLD_CYC     = 2,
    parameter int BUSY_TIMEOUT = 1024
) (
    input  logic       i_EMUCLK,
    input  logic       i_RST,
    input  logic       i_REQ_VALID,
    output logic       o_REQ_READY,
    input  logic [7:0] i_REQ_ADDR,
    input  logic [7:0] i_REQ_DATA,
    output logic       o_DONE,
    output logic       o_TIMEOUT,
    output logic       o_ACTIVE,
    output logic [7:0] o_STATUS,
    output logic       o_CS_n,
    output logic       o_RD_n,
    output logic       o_WR_n,
    output logic       o_A0,
    output logic [7:0] o_D,
    output logic       o_D_OE,
    input  logic [7:0] i_D
);

    typedef enum logic [1:0] {S_IDLE, S_POLL, S_ADDR, S_DATA} state_t;
    typedef enum logic [1:0] {P_SETUP, P_STROBE, P_HOLD, P_GAP} phase_t;

    localparam logic [7:0]  SETUP_LAST = 8'(SETUP_CYC - 1);
    localparam logic [7:0]  PULSE_LAST = 8'(PULSE_CYC - 1);
    localparam logic [7:0]  HOLD_LAST  = 8'(HOLD_CYC - 1);
    localparam logic [15:0] TIMEOUT    = 16'(BUSY_TIMEOUT);

    state_t      state_q, state_d;
    phase_t      phase_q, phase_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] poll_q, poll_d;
    logic [7:0]  status_q, status_d;
    logic [7:0]  addr_q, data_q;
    logic        accept;
    logic        phase_last;
    logic [15:0] poll_inc;
    logic        busy_abort;

    assign accept   = i_REQ_VALID && (state_q == S_IDLE);
    assign poll_inc = (poll_q == 16'hFFFF) ? poll_q : poll_q + 16'd1;
    assign busy_abort = (TIMEOUT != 16'd0) && (poll_inc == TIMEOUT);
    assign o_STATUS = status_q;
    assign o_ACTIVE = (state_q != S_IDLE);

    // Last cycle of the current bus phase.
    always_comb begin
        phase_last = 1'b1;
        case (phase_q)
            P_SETUP:  phase_last = (cnt_q == SETUP_LAST);
            P_STROBE: phase_last = (cnt_q == PULSE_LAST);
            P_HOLD:   phase_last = (cnt_q == HOLD_LAST);
            default:  phase_last = 1'b1;
        endcase
    end

    // Sequencer, phase and poll counter registers.
    always_ff @(posedge i_EMUCLK) begin
        if (i_RST) begin
            state_q  <= S_IDLE;
            phase_q  <= P_SETUP;
            cnt_q    <= 8'd0;
            poll_q   <= 16'd0;
            status_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            poll_q   <= poll_d;
            status_q <= status_d;
        end
    end

    // Request capture on the accepting edge.
    always_ff @(posedge i_EMUCLK) begin
        if (i_RST) begin
            addr_q <= 8'd0;
            data_q <= 8'd0;
        end else if (accept) begin
            addr_q <= i_REQ_ADDR;
            data_q <= i_REQ_DATA;
        end
    end

    // Next-state and bus output decode.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        cnt_d       = cnt_q;
        poll_d      = poll_q;
        status_d    = status_q;
        o_REQ_READY = 1'b0;
        o_DONE      = 1'b0;
        o_TIMEOUT   = 1'b0;
        o_CS_n      = 1'b1;
        o_RD_n      = 1'b1;
        o_WR_n      = 1'b1;
        o_A0        = 1'b0;
        o_D         = 8'd0;
        o_D_OE      = 1'b0;
        if (state_q == S_IDLE) begin
            o_REQ_READY = 1'b1;
            if (i_REQ_VALID) begin
                state_d = S_POLL;
                phase_d = P_SETUP;
                cnt_d   = 8'd0;
                poll_d  = 16'd0;
            end
        end else begin
            if (phase_q != P_GAP) begin
                o_CS_n = 1'b0;
                if (state_q != S_POLL) begin
                    o_D_OE = 1'b1;
                    o_A0   = (state_q == S_DATA);
                    o_D    = (state_q == S_DATA) ? data_q : addr_q;
                end
            end
            if (phase_q == P_STROBE) begin
                if (state_q == S_POLL) o_RD_n = 1'b0;
                else                   o_WR_n = 1'b0;
            end
            if (phase_last) begin
                cnt_d = 8'd0;
                case (phase_q)
                    P_SETUP:  phase_d = P_STROBE;
                    P_STROBE: phase_d = P_HOLD;
                    P_HOLD:   phase_d = P_GAP;
                    default:  phase_d = P_SETUP;
                endcase
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
            if (state_q == S_POLL && phase_q == P_STROBE && phase_last)
                status_d = i_D;
            if (phase_q == P_GAP) begin
                case (state_q)
                    S_POLL: begin
                        if (!status_q[7]) begin
                            state_d = S_ADDR;
                        end else begin
                            poll_d = poll_inc;
                            if (busy_abort) begin
                                o_TIMEOUT = 1'b1;
                                state_d   = S_IDLE;
                            end
                        end
                    end
                    S_ADDR: state_d = S_DATA;
                    default: begin
                        o_DONE  = 1'b1;
                        state_d = S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ika2151_bus_master.sv
// tb_ika2151_bus_master: randomized checks of the OPM bus master
// against a cycle trace built from the access rules.
module tb_ika2151_bus_master;

    typedef struct packed {
        logic       ready;
        logic       done;
        logic       tout;
        logic       active;
        logic       cs_n;
        logic       rd_n;
        logic       wr_n;
        logic       a0;
        logic [7:0] d;
        logic       oe;
        logic [7:0] status;
    } out_t;

    typedef struct packed {
        logic       rst;
        logic       chk;
        logic       vin;
        logic [7:0] ain;
        logic [7:0] dn;
        logic [7:0] din;
        out_t       exp;
    } ent_t;

    logic       clk;
    logic       rst;
    logic       vin;
    logic [7:0] ain;
    logic [7:0] dn;
    logic [7:0] din;

    logic       a_ready, a_done, a_tout, a_active;
    logic [7:0] a_status, a_d;
    logic       a_cs_n, a_rd_n, a_wr_n, a_a0, a_oe;
    logic       b_ready, b_done, b_tout, b_active;
    logic [7:0] b_status, b_d;
    logic       b_cs_n, b_rd_n, b_wr_n, b_a0, b_oe;

    out_t obs_a, obs_b;
    ent_t q[$];
    logic [7:0] m_st;
    int errors;
    int checks;

    ika2151_bus_master #(
        .SETUP_CYC(2), .PULSE_CYC(4), .HOLD_CYC(2), .BUSY_TIMEOUT(4)
    ) u_a (
        .i_EMUCLK(clk), .i_RST(rst),
        .i_REQ_VALID(vin), .o_REQ_READY(a_ready),
        .i_REQ_ADDR(ain), .i_REQ_DATA(dn),
        .o_DONE(a_done), .o_TIMEOUT(a_tout),
        .o_ACTIVE(a_active), .o_STATUS(a_status),
        .o_CS_n(a_cs_n), .o_RD_n(a_rd_n), .o_WR_n(a_wr_n),
        .o_A0(a_a0), .o_D(a_d), .o_D_OE(a_oe), .i_D(din)
    );

    ika2151_bus_master #(
        .SETUP_CYC(1), .PULSE_CYC(1), .HOLD_CYC(1), .BUSY_TIMEOUT(0)
    ) u_b (
        .i_EMUCLK(clk), .i_RST(rst),
        .i_REQ_VALID(vin), .o_REQ_READY(b_ready),
        .i_REQ_ADDR(ain), .i_REQ_DATA(dn),
        .o_DONE(b_done), .o_TIMEOUT(b_tout),
        .o_ACTIVE(b_active), .o_STATUS(b_status),
        .o_CS_n(b_cs_n), .o_RD_n(b_rd_n), .o_WR_n(b_wr_n),
        .o_A0(b_a0), .o_D(b_d), .o_D_OE(b_oe), .i_D(din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic out_t idle_out();
        out_t o;
        o = '0;
        o.ready  = 1'b1;
        o.cs_n   = 1'b1;
        o.rd_n   = 1'b1;
        o.wr_n   = 1'b1;
        o.status = m_st;
        return o;
    endfunction

    function automatic void add_reset(int n);
        ent_t e;
        for (int i = 0; i < n; i++) begin
            e.rst = 1'b1;
            e.chk = (i != 0);
            e.vin = 1'($urandom);
            e.ain = 8'($urandom);
            e.dn  = 8'($urandom);
            e.din = 8'($urandom);
            e.exp = idle_out();
            q.push_back(e);
            m_st = 8'd0;
        end
    endfunction

    function automatic void add_idle(logic v, logic [7:0] wa,
                                     logic [7:0] wd);
        ent_t e;
        e.rst = 1'b0;
        e.chk = 1'b1;
        e.vin = v;
        e.ain = wa;
        e.dn  = wd;
        e.din = 8'($urandom);
        e.exp = idle_out();
        q.push_back(e);
    endfunction

    // kind: 0 status read, 1 address write, 2 data write
    function automatic void add_access(int s, int p, int h, int kind,
                                       logic [7:0] wa, logic [7:0] wd,
                                       logic [7:0] rd, logic fin);
        ent_t e;
        out_t o;
        int len;
        len = s + p + h + 1;
        for (int j = 0; j < len; j++) begin
            if (kind == 0 && j == s + p) m_st = rd;
            o = idle_out();
            o.ready  = 1'b0;
            o.active = 1'b1;
            if (j < s + p + h) begin
                o.cs_n = 1'b0;
                if (kind != 0) begin
                    o.oe = 1'b1;
                    o.a0 = (kind == 2);
                    o.d  = (kind == 2) ? wd : wa;
                end
            end
            if (j >= s && j < s + p) begin
                if (kind == 0) o.rd_n = 1'b0;
                else           o.wr_n = 1'b0;
            end
            if (j == len - 1 && fin) begin
                if (kind == 2) o.done = 1'b1;
                else           o.tout = 1'b1;
            end
            e.rst = 1'b0;
            e.chk = 1'b1;
            e.vin = 1'($urandom);
            e.ain = 8'($urandom);
            e.dn  = 8'($urandom);
            e.din = (kind == 0) ? rd : 8'($urandom);
            e.exp = o;
            q.push_back(e);
        end
    endfunction

    function automatic void add_txn(int s, int p, int h, int bt,
                                    logic [7:0] wa, logic [7:0] wd,
                                    int nbusy);
        int cnt;
        logic to;
        cnt = 0;
        add_idle(1'b1, wa, wd);
        for (int pp = 0; pp < 64; pp++) begin
            if (pp < nbusy) begin
                cnt++;
                to = (bt != 0) && (cnt == bt);
                add_access(s, p, h, 0, 8'd0, 8'd0,
                           8'h80 | 8'($urandom), to);
                if (to) return;
            end else begin
                add_access(s, p, h, 0, 8'd0, 8'd0,
                           8'($urandom) & 8'h7f, 1'b0);
                break;
            end
        end
        add_access(s, p, h, 1, wa, wd, 8'd0, 1'b0);
        add_access(s, p, h, 2, wa, wd, 8'd0, 1'b1);
    endfunction

    task automatic step(input ent_t e);
        rst = e.rst;
        vin = e.vin;
        ain = e.ain;
        dn  = e.dn;
        din = e.din;
        @(negedge clk);
        obs_a = {a_ready, a_done, a_tout, a_active, a_cs_n, a_rd_n,
                 a_wr_n, a_a0, a_d, a_oe, a_status};
        obs_b = {b_ready, b_done, b_tout, b_active, b_cs_n, b_rd_n,
                 b_wr_n, b_a0, b_d, b_oe, b_status};
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        q.delete();
        add_reset(3);
        add_idle(1'b0, 8'd0, 8'd0);
        foreach (q[i]) begin
            step(q[i]);
            if (q[i].chk) begin
                checks++;
                if (obs_a !== q[i].exp) begin
                    errors++;
                    $display("FAIL reset_a cyc=%0d got=%h exp=%h",
                             i, obs_a, q[i].exp);
                end
                checks++;
                if (obs_b !== q[i].exp) begin
                    errors++;
                    $display("FAIL reset_b cyc=%0d got=%h exp=%h",
                             i, obs_b, q[i].exp);
                end
            end
        end
    endtask

    task automatic test_single();
        q.delete();
        add_reset(2);
        add_txn(2, 4, 2, 4, 8'h20, 8'hC7, 0);
        add_idle(1'b0, 8'd0, 8'd0);
        foreach (q[i]) begin
            step(q[i]);
            if (q[i].chk) begin
                checks++;
                if (obs_a !== q[i].exp) begin
                    errors++;
                    $display("FAIL single cyc=%0d got=%h exp=%h",
                             i, obs_a, q[i].exp);
                end
            end
        end
    endtask

    task automatic test_busy_wait();
        q.delete();
        add_reset(2);
        add_txn(2, 4, 2, 4, 8'h08, 8'h5A, 3);
        add_idle(1'b0, 8'd0, 8'd0);
        foreach (q[i]) begin
            step(q[i]);
            if (q[i].chk) begin
                checks++;
                if (obs_a !== q[i].exp) begin
                    errors++;
                    $display("FAIL busy cyc=%0d got=%h exp=%h",
                             i, obs_a, q[i].exp);
                end
            end
        end
    endtask

    task automatic test_timeout();
        q.delete();
        add_reset(2);
        add_txn(2, 4, 2, 4, 8'h28, 8'h3F, 1000);
        add_idle(1'b0, 8'd0, 8'd0);
        add_idle(1'b0, 8'd0, 8'd0);
        foreach (q[i]) begin
            step(q[i]);
            if (q[i].chk) begin
                checks++;
                if (obs_a !== q[i].exp) begin
                    errors++;
                    $display("FAIL timeout cyc=%0d got=%h exp=%h",
                             i, obs_a, q[i].exp);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        q.delete();
        add_reset(2);
        add_txn(2, 4, 2, 4, 8'h30, 8'h11, 0);
        add_txn(2, 4, 2, 4, 8'h38, 8'hE4, 0);
        add_idle(1'b0, 8'd0, 8'd0);
        foreach (q[i]) begin
            step(q[i]);
            if (q[i].chk) begin
                checks++;
                if (obs_a !== q[i].exp) begin
                    errors++;
                    $display("FAIL b2b cyc=%0d got=%h exp=%h",
                             i, obs_a, q[i].exp);
                end
            end
        end
    endtask

    task automatic test_random();
        q.delete();
        add_reset(2);
        for (int t = 0; t < 8; t++) begin
            if ($urandom_range(0, 1) == 1)
                add_idle(1'b0, 8'($urandom), 8'($urandom));
            add_txn(2, 4, 2, 4, 8'($urandom), 8'($urandom),
                    $urandom_range(0, 5));
        end
        add_idle(1'b0, 8'd0, 8'd0);
        foreach (q[i]) begin
            step(q[i]);
            if (q[i].chk) begin
                checks++;
                if (obs_a !== q[i].exp) begin
                    errors++;
                    $display("FAIL random cyc=%0d got=%h exp=%h",
                             i, obs_a, q[i].exp);
                end
            end
        end
    endtask

    task automatic test_min_timing();
        q.delete();
        add_reset(2);
        add_txn(1, 1, 1, 0, 8'h1B, 8'h96, 0);
        for (int t = 0; t < 4; t++)
            add_txn(1, 1, 1, 0, 8'($urandom), 8'($urandom),
                    $urandom_range(0, 3));
        add_idle(1'b0, 8'd0, 8'd0);
        foreach (q[i]) begin
            step(q[i]);
            if (q[i].chk) begin
                checks++;
                if (obs_b !== q[i].exp) begin
                    errors++;
                    $display("FAIL min_timing cyc=%0d got=%h exp=%h",
                             i, obs_b, q[i].exp);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        ent_t e;
        int idx;
        q.delete();
        add_reset(2);
        idx = q.size() + 1 + 2 * 4 + 1;
        add_txn(1, 1, 1, 0, 8'h44, 8'hA5, 0);
        while (q.size() > idx + 1) void'(q.pop_back());
        e = q[idx];
        e.rst = 1'b1;
        q[idx] = e;
        m_st = 8'd0;
        for (int t = 0; t < 4; t++) add_idle(1'b0, 8'd0, 8'd0);
        foreach (q[i]) begin
            step(q[i]);
            if (q[i].chk) begin
                checks++;
                if (obs_b !== q[i].exp) begin
                    errors++;
                    $display("FAIL reset_mid cyc=%0d got=%h exp=%h",
                             i, obs_b, q[i].exp);
                end
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        m_st   = 8'd0;
        rst    = 1'b1;
        vin    = 1'b0;
        ain    = 8'd0;
        dn     = 8'd0;
        din    = 8'd0;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_busy_wait();
        test_timeout();
        test_back_to_back();
        test_random();
        test_min_timing();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
